// File: rtl/gnr_node_mc_if.sv
// Bundles the gnr_node_mc control, regulator inputs and per-channel outputs.
// With GNR_CHANGE_CNT_EN defined, the interface also carries chg_cnt.
interface gnr_node_mc_if #(
  parameter int NCH   = 2,
  parameter int NIN   = 3,
  parameter int DIV_W = 4,
  parameter int CNT_W = 8
);
  logic                   reset_nos;
  logic [NCH-1:0]         init_state;
  logic [NCH-1:0]         start;
  logic [NCH*DIV_W-1:0]   period;
  logic [NCH*NIN-1:0]     in_s;
  logic [NIN-1:0]         in_mask;
  logic [NIN-1:0]         in_inv;
  logic                   op_or;
  logic [NCH-1:0]         state;
  logic [NCH-1:0]         eval_pulse;
`ifdef GNR_CHANGE_CNT_EN
  logic [NCH*CNT_W-1:0]   chg_cnt;

  modport master (
    output reset_nos, init_state, start, period, in_s, in_mask, in_inv, op_or,
    input  state, eval_pulse, chg_cnt
  );
  modport slave (
    input  reset_nos, init_state, start, period, in_s, in_mask, in_inv, op_or,
    output state, eval_pulse, chg_cnt
  );
`else
  modport master (
    output reset_nos, init_state, start, period, in_s, in_mask, in_inv, op_or,
    input  state, eval_pulse
  );
  modport slave (
    input  reset_nos, init_state, start, period, in_s, in_mask, in_inv, op_or,
    output state, eval_pulse
  );
`endif
endinterface

// File: rtl/gnr_node_mc.sv
// Multi-channel gene-regulatory node: each channel evaluates a masked AND/OR of its
// inputs every (period+1)-th start. Optional change counters: GNR_CHANGE_CNT_EN.
module gnr_node_mc #(
  parameter int NCH   = 2,
  parameter int NIN   = 3,
  parameter int DIV_W = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  gnr_node_mc_if.slave    bus
);

  logic [NCH-1:0]   f;
  logic [NCH-1:0]   state_q, state_d;
  logic [NCH-1:0]   pulse_q, pulse_d;
  logic [DIV_W-1:0] ph_q [NCH];
  logic [DIV_W-1:0] ph_d [NCH];
`ifdef GNR_CHANGE_CNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
`endif

  // Start value is the identity of the reduction, so an all-masked channel yields 1/0.
  always_comb begin
    f = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      f[c] = ~bus.op_or;
      for (int unsigned i = 0; i < NIN; i++) begin
        if (bus.in_mask[i]) begin
          if (bus.op_or) f[c] = f[c] | (bus.in_s[c*NIN+i] ^ bus.in_inv[i]);
          else           f[c] = f[c] & (bus.in_s[c*NIN+i] ^ bus.in_inv[i]);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      ph_d[c] = ph_q[c];
`ifdef GNR_CHANGE_CNT_EN
      cnt_d[c] = cnt_q[c];
`endif
      if (rst) begin
        state_d[c] = 1'b0;
        ph_d[c]    = bus.period[c*DIV_W +: DIV_W];
`ifdef GNR_CHANGE_CNT_EN
        cnt_d[c]   = '0;
`endif
      end else if (bus.reset_nos) begin
        state_d[c] = bus.init_state[c];
        ph_d[c]    = '0;
`ifdef GNR_CHANGE_CNT_EN
        cnt_d[c]   = '0;
`endif
      end else if (bus.start[c]) begin
        if (ph_q[c] == '0) begin
          state_d[c] = f[c];
          ph_d[c]    = bus.period[c*DIV_W +: DIV_W];
          pulse_d[c] = 1'b1;
`ifdef GNR_CHANGE_CNT_EN
          if (f[c] != state_q[c] && cnt_q[c] != '1) cnt_d[c] = cnt_q[c] + 1'b1;
`endif
        end else begin
          ph_d[c] = ph_q[c] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    pulse_q <= pulse_d;
    for (int unsigned c = 0; c < NCH; c++) begin
      ph_q[c] <= ph_d[c];
`ifdef GNR_CHANGE_CNT_EN
      cnt_q[c] <= cnt_d[c];
`endif
    end
  end

  assign bus.state      = state_q;
  assign bus.eval_pulse = pulse_q;

`ifdef GNR_CHANGE_CNT_EN
  always_comb begin
    bus.chg_cnt = '0;
    for (int unsigned c = 0; c < NCH; c++) bus.chg_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
  end
`endif

endmodule
